// File: rtl/controle_mc_if.sv
// Control/status bundle between the multicycle MIPS datapath and its controller.
// The controller uses the slave modport; the datapath side uses master.
interface controle_mc_if;
   logic [5:0] OpCode;
   logic [5:0] funct;
   logic       Overflow;
   logic       Zero;

   logic       PCWrite;
   logic       MemCtrl;
   logic       IRWrite;
   logic       A_Control;
   logic       B_Control;
   logic       RegControl;
   logic       ALUOutControl;
   logic       EPCWrite;
   logic       MDControl;
   logic [1:0] IorD;
   logic [1:0] ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [1:0] ExcpCtrl;
   logic [2:0] RegDst;
   logic [2:0] PCSource;
   logic [2:0] ALUControl;
   logic [3:0] DataSrc;
   logic [6:0] estado;

   modport slave (
      input  OpCode, funct, Overflow, Zero,
      output PCWrite, MemCtrl, IRWrite, A_Control, B_Control, RegControl,
             ALUOutControl, EPCWrite, MDControl, IorD, ALUSrcA, ALUSrcB,
             ExcpCtrl, RegDst, PCSource, ALUControl, DataSrc, estado
   );

   modport master (
      output OpCode, funct, Overflow, Zero,
      input  PCWrite, MemCtrl, IRWrite, A_Control, B_Control, RegControl,
             ALUOutControl, EPCWrite, MDControl, IorD, ALUSrcA, ALUSrcB,
             ExcpCtrl, RegDst, PCSource, ALUControl, DataSrc, estado
   );
endinterface

// File: rtl/controle_mc.sv
// Multicycle MIPS control unit: Moore FSM with memory wait states, load/store,
// BEQ/BNE, BREAK and overflow / invalid-opcode exceptions via EPC and vector fetch.
module controle_mc #(
   parameter int unsigned MEM_WAIT = 2,
   parameter bit          OVF_EN   = 1'b1
) (
   input logic          clk,
   input logic          reset,
   controle_mc_if.slave bus
);

   localparam int unsigned CNT_W   = 3;
   localparam int unsigned STATE_W = 7;
   localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MEM_WAIT - 1);

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ADDIU = 6'b001001;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [5:0] FN_ADD   = 6'b100000;
   localparam logic [5:0] FN_SUB   = 6'b100010;
   localparam logic [5:0] FN_AND   = 6'b100100;
   localparam logic [5:0] FN_BREAK = 6'b001101;

   localparam logic [1:0] CAUSE_OPC = 2'b00;
   localparam logic [1:0] CAUSE_OVF = 2'b01;

   typedef enum logic [STATE_W-1:0] {
      S_FETCH    = 7'd0,
      S_FETCH_WR = 7'd1,
      S_DECODE   = 7'd2,
      S_DISPATCH = 7'd3,
      S_R_EXEC   = 7'd4,
      S_R_WB     = 7'd5,
      S_I_EXEC   = 7'd6,
      S_I_WB     = 7'd7,
      S_MEM_ADDR = 7'd8,
      S_MEM_ACC  = 7'd9,
      S_LW_MDR   = 7'd10,
      S_LW_WB    = 7'd11,
      S_BRANCH   = 7'd12,
      S_BRK      = 7'd13,
      S_EXC_EPC  = 7'd14,
      S_EXC_WAIT = 7'd15,
      S_EXC_JMP  = 7'd16
   } state_t;

   state_t           state, state_nx;
   logic [CNT_W-1:0] wait_cnt, wait_cnt_nx;
   logic [1:0]       cause, cause_nx;
   logic             wait_done;
   logic             r_trap, i_trap;

   assign wait_done = (wait_cnt == WAIT_LAST);
   assign r_trap    = OVF_EN && bus.Overflow && ((bus.funct == FN_ADD) || (bus.funct == FN_SUB));
   assign i_trap    = OVF_EN && bus.Overflow && (bus.OpCode == OP_ADDI);

   // State, wait counter and exception cause registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= S_FETCH;
         wait_cnt <= '0;
         cause    <= '0;
      end else begin
         state    <= state_nx;
         wait_cnt <= wait_cnt_nx;
         cause    <= cause_nx;
      end
   end

   // Next-state logic; wait_cnt clears whenever a wait state is not being extended
   always_comb begin
      state_nx    = state;
      wait_cnt_nx = '0;
      cause_nx    = cause;
      case (state)
         S_FETCH: begin
            if (wait_done) state_nx = S_FETCH_WR;
            else           wait_cnt_nx = wait_cnt + CNT_W'(1);
         end
         S_FETCH_WR: state_nx = S_DECODE;
         S_DECODE:   state_nx = S_DISPATCH;
         S_DISPATCH: begin
            case (bus.OpCode)
               OP_RTYPE: begin
                  case (bus.funct)
                     FN_ADD, FN_SUB, FN_AND: state_nx = S_R_EXEC;
                     FN_BREAK:               state_nx = S_BRK;
                     default: begin
                        state_nx = S_EXC_EPC;
                        cause_nx = CAUSE_OPC;
                     end
                  endcase
               end
               OP_ADDI, OP_ADDIU: state_nx = S_I_EXEC;
               OP_LW, OP_SW:      state_nx = S_MEM_ADDR;
               OP_BEQ, OP_BNE:    state_nx = S_BRANCH;
               default: begin
                  state_nx = S_EXC_EPC;
                  cause_nx = CAUSE_OPC;
               end
            endcase
         end
         S_R_EXEC: begin
            if (r_trap) begin
               state_nx = S_EXC_EPC;
               cause_nx = CAUSE_OVF;
            end else begin
               state_nx = S_R_WB;
            end
         end
         S_R_WB: state_nx = S_FETCH;
         S_I_EXEC: begin
            if (i_trap) begin
               state_nx = S_EXC_EPC;
               cause_nx = CAUSE_OVF;
            end else begin
               state_nx = S_I_WB;
            end
         end
         S_I_WB:     state_nx = S_FETCH;
         S_MEM_ADDR: state_nx = S_MEM_ACC;
         S_MEM_ACC: begin
            if (bus.OpCode == OP_SW)   state_nx = S_FETCH;
            else if (wait_done)        state_nx = S_LW_MDR;
            else                       wait_cnt_nx = wait_cnt + CNT_W'(1);
         end
         S_LW_MDR:  state_nx = S_LW_WB;
         S_LW_WB:   state_nx = S_FETCH;
         S_BRANCH:  state_nx = S_FETCH;
         S_BRK:     state_nx = S_FETCH;
         S_EXC_EPC: state_nx = S_EXC_WAIT;
         S_EXC_WAIT: begin
            if (wait_done) state_nx = S_EXC_JMP;
            else           wait_cnt_nx = wait_cnt + CNT_W'(1);
         end
         S_EXC_JMP: begin
            state_nx = S_FETCH;
            cause_nx = '0;
         end
         default: state_nx = S_FETCH;
      endcase
   end

   // Moore output decode; everything is forced low while reset is held
   always_comb begin
      bus.PCWrite       = 1'b0;
      bus.MemCtrl       = 1'b0;
      bus.IRWrite       = 1'b0;
      bus.A_Control     = 1'b0;
      bus.B_Control     = 1'b0;
      bus.RegControl    = 1'b0;
      bus.ALUOutControl = 1'b0;
      bus.EPCWrite      = 1'b0;
      bus.MDControl     = 1'b0;
      bus.IorD          = 2'b00;
      bus.ALUSrcA       = 2'b00;
      bus.ALUSrcB       = 2'b00;
      bus.ExcpCtrl      = 2'b00;
      bus.RegDst        = 3'b000;
      bus.PCSource      = 3'b000;
      bus.ALUControl    = 3'b000;
      bus.DataSrc       = 4'b0000;
      bus.estado        = reset ? STATE_W'(state) : '0;
      if (reset) begin
         case (state)
            S_FETCH: begin
               bus.ALUSrcB    = 2'b01;
               bus.ALUControl = 3'b001;
            end
            S_FETCH_WR: begin
               bus.IRWrite    = 1'b1;
               bus.PCWrite    = 1'b1;
               bus.ALUSrcB    = 2'b01;
               bus.ALUControl = 3'b001;
            end
            S_DECODE: begin
               bus.A_Control     = 1'b1;
               bus.B_Control     = 1'b1;
               bus.ALUSrcB       = 2'b11;
               bus.ALUControl    = 3'b001;
               bus.ALUOutControl = 1'b1;
            end
            S_R_EXEC: begin
               bus.ALUSrcA       = 2'b01;
               bus.ALUOutControl = 1'b1;
               case (bus.funct)
                  FN_SUB:  bus.ALUControl = 3'b010;
                  FN_AND:  bus.ALUControl = 3'b011;
                  default: bus.ALUControl = 3'b001;
               endcase
            end
            S_R_WB: begin
               bus.RegDst     = 3'b001;
               bus.RegControl = 1'b1;
            end
            S_I_EXEC, S_MEM_ADDR: begin
               bus.ALUSrcA       = 2'b01;
               bus.ALUSrcB       = 2'b10;
               bus.ALUControl    = 3'b001;
               bus.ALUOutControl = 1'b1;
            end
            S_I_WB: bus.RegControl = 1'b1;
            S_MEM_ACC: begin
               bus.IorD    = 2'b01;
               bus.MemCtrl = (bus.OpCode == OP_SW);
            end
            S_LW_MDR: bus.MDControl = 1'b1;
            S_LW_WB: begin
               bus.DataSrc    = 4'b0001;
               bus.RegControl = 1'b1;
            end
            S_BRANCH: begin
               bus.ALUSrcA    = 2'b01;
               bus.ALUControl = 3'b010;
               bus.PCSource   = 3'b001;
               bus.PCWrite    = (bus.OpCode == OP_BNE) ? ~bus.Zero : bus.Zero;
            end
            S_BRK: begin
               bus.ALUSrcB    = 2'b01;
               bus.ALUControl = 3'b010;
               bus.PCWrite    = 1'b1;
            end
            S_EXC_EPC: begin
               bus.ALUSrcB    = 2'b01;
               bus.ALUControl = 3'b010;
               bus.EPCWrite   = 1'b1;
               bus.IorD       = 2'b10;
               bus.ExcpCtrl   = cause;
            end
            S_EXC_WAIT: begin
               bus.IorD     = 2'b10;
               bus.ExcpCtrl = cause;
            end
            S_EXC_JMP: begin
               bus.PCSource = 3'b010;
               bus.PCWrite  = 1'b1;
               bus.ExcpCtrl = cause;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_controle_mc.sv
// Scoreboard bench for controle_mc: three parameter sets exercised one at a time,
// expected per-cycle outputs derived from an instruction-level model.
module tb_controle_mc;

   typedef struct packed {
      logic [6:0] st;
      logic       pcw, memc, irw, ac, bc, rc, aoc, epcw, mdc;
      logic [1:0] iord, srca, srcb, excp;
      logic [2:0] regdst, pcsrc, aluc;
      logic [3:0] datasrc;
   } obs_t;

   localparam int LIMIT = 20000;

   logic       clk = 1'b0;
   logic       rst0, rst1, rst2;
   logic [5:0] op, fn;
   logic       ovf, zero;
   int         sel;
   bit         stim_done;

   obs_t exp_q[$];
   obs_t act0, act1, act2, act, expv;
   int   n_checks, n_fail, cyc;

   always #5 clk = ~clk;

   controle_mc_if b0();
   controle_mc_if b1();
   controle_mc_if b2();

   assign b0.OpCode = op; assign b0.funct = fn; assign b0.Overflow = ovf; assign b0.Zero = zero;
   assign b1.OpCode = op; assign b1.funct = fn; assign b1.Overflow = ovf; assign b1.Zero = zero;
   assign b2.OpCode = op; assign b2.funct = fn; assign b2.Overflow = ovf; assign b2.Zero = zero;

   controle_mc #(.MEM_WAIT(2), .OVF_EN(1'b1)) u_dut0 (.clk(clk), .reset(rst0), .bus(b0));
   controle_mc #(.MEM_WAIT(2), .OVF_EN(1'b0)) u_dut1 (.clk(clk), .reset(rst1), .bus(b1));
   controle_mc #(.MEM_WAIT(4), .OVF_EN(1'b1)) u_dut2 (.clk(clk), .reset(rst2), .bus(b2));

   assign act0 = {b0.estado, b0.PCWrite, b0.MemCtrl, b0.IRWrite, b0.A_Control, b0.B_Control,
                  b0.RegControl, b0.ALUOutControl, b0.EPCWrite, b0.MDControl, b0.IorD,
                  b0.ALUSrcA, b0.ALUSrcB, b0.ExcpCtrl, b0.RegDst, b0.PCSource,
                  b0.ALUControl, b0.DataSrc};
   assign act1 = {b1.estado, b1.PCWrite, b1.MemCtrl, b1.IRWrite, b1.A_Control, b1.B_Control,
                  b1.RegControl, b1.ALUOutControl, b1.EPCWrite, b1.MDControl, b1.IorD,
                  b1.ALUSrcA, b1.ALUSrcB, b1.ExcpCtrl, b1.RegDst, b1.PCSource,
                  b1.ALUControl, b1.DataSrc};
   assign act2 = {b2.estado, b2.PCWrite, b2.MemCtrl, b2.IRWrite, b2.A_Control, b2.B_Control,
                  b2.RegControl, b2.ALUOutControl, b2.EPCWrite, b2.MDControl, b2.IorD,
                  b2.ALUSrcA, b2.ALUSrcB, b2.ExcpCtrl, b2.RegDst, b2.PCSource,
                  b2.ALUControl, b2.DataSrc};

   // Output table of each architectural state for the instruction in flight
   function automatic obs_t exp_outs(input int st, input logic [5:0] o, input logic [5:0] f,
                                     input logic z, input logic [1:0] c);
      obs_t e;
      e = '0;
      e.st = 7'(st);
      case (st)
         0:  begin e.srcb = 2'd1; e.aluc = 3'd1; end
         1:  begin e.irw = 1'b1; e.pcw = 1'b1; e.srcb = 2'd1; e.aluc = 3'd1; end
         2:  begin e.ac = 1'b1; e.bc = 1'b1; e.srcb = 2'd3; e.aluc = 3'd1; e.aoc = 1'b1; end
         4:  begin
                e.srca = 2'd1; e.aoc = 1'b1;
                e.aluc = (f == 6'h22) ? 3'd2 : (f == 6'h24) ? 3'd3 : 3'd1;
             end
         5:  begin e.regdst = 3'd1; e.rc = 1'b1; end
         6, 8: begin e.srca = 2'd1; e.srcb = 2'd2; e.aluc = 3'd1; e.aoc = 1'b1; end
         7:  e.rc = 1'b1;
         9:  begin e.iord = 2'd1; e.memc = (o == 6'h2B); end
         10: e.mdc = 1'b1;
         11: begin e.datasrc = 4'd1; e.rc = 1'b1; end
         12: begin
                e.srca = 2'd1; e.aluc = 3'd2; e.pcsrc = 3'd1;
                e.pcw = (o == 6'h04) ? z : !z;
             end
         13: begin e.srcb = 2'd1; e.aluc = 3'd2; e.pcw = 1'b1; end
         14: begin e.srcb = 2'd1; e.aluc = 3'd2; e.epcw = 1'b1; e.iord = 2'd2; e.excp = c; end
         15: begin e.iord = 2'd2; e.excp = c; end
         16: begin e.pcsrc = 3'd2; e.pcw = 1'b1; e.excp = c; end
         default: ;
      endcase
      return e;
   endfunction

   function automatic int cur_mw();
      return (sel == 2) ? 4 : 2;
   endfunction

   task automatic set_rst(input logic v);
      case (sel)
         0: rst0 = v;
         1: rst1 = v;
         default: rst2 = v;
      endcase
   endtask

   // Instruction-level model: state walk derived from the instruction class
   task automatic build(input logic [5:0] o, input logic [5:0] f, input logic v,
                        output int seq[$], output logic [1:0] c);
      int  mw;
      bit  oe, exc;
      mw  = cur_mw();
      oe  = (sel != 1);
      exc = 1'b0;
      c   = 2'b00;
      seq = {};
      for (int i = 0; i < mw; i++) seq.push_back(0);
      seq.push_back(1); seq.push_back(2); seq.push_back(3);
      if (o == 6'h00 && (f == 6'h20 || f == 6'h22 || f == 6'h24)) begin
         seq.push_back(4);
         if (oe && v && f != 6'h24) begin exc = 1'b1; c = 2'b01; end
         else seq.push_back(5);
      end else if (o == 6'h00 && f == 6'h0D) begin
         seq.push_back(13);
      end else if (o == 6'h08 || o == 6'h09) begin
         seq.push_back(6);
         if (oe && v && o == 6'h08) begin exc = 1'b1; c = 2'b01; end
         else seq.push_back(7);
      end else if (o == 6'h23 || o == 6'h2B) begin
         seq.push_back(8);
         if (o == 6'h2B) seq.push_back(9);
         else begin
            for (int i = 0; i < mw; i++) seq.push_back(9);
            seq.push_back(10); seq.push_back(11);
         end
      end else if (o == 6'h04 || o == 6'h05) begin
         seq.push_back(12);
      end else begin
         exc = 1'b1;
      end
      if (exc) begin
         seq.push_back(14);
         for (int i = 0; i < mw; i++) seq.push_back(15);
         seq.push_back(16);
      end
   endtask

   task automatic run(input logic [5:0] o, input logic [5:0] f, input logic v, input logic z);
      int         seq[$];
      logic [1:0] c;
      op = o; fn = f; ovf = v; zero = z;
      build(o, f, v, seq, c);
      foreach (seq[i]) exp_q.push_back(exp_outs(seq[i], o, f, z, c));
      repeat (seq.size()) @(posedge clk);
      #1;
   endtask

   // LW interrupted by reset in its second MEM_ACC cycle
   task automatic lw_reset();
      int         seq[$];
      logic [1:0] c;
      int         n;
      op = 6'h23; fn = 6'h00; ovf = 1'b0; zero = 1'b0;
      build(op, fn, ovf, seq, c);
      n = cur_mw() + 5;
      for (int i = 0; i < n; i++) exp_q.push_back(exp_outs(seq[i], op, fn, zero, c));
      repeat (n) @(posedge clk);
      #1;
      set_rst(1'b0);
      repeat (3) @(posedge clk);
      #1;
      set_rst(1'b1);
   endtask

   // Stimulus
   initial begin
      logic [5:0] ro, rf;
      rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
      sel = 0; op = '0; fn = '0; ovf = 1'b0; zero = 1'b0; stim_done = 1'b0;
      #1;
      rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
      for (int s = 0; s < 3; s++) begin
         sel = s;
         repeat (3) @(posedge clk);
         #1;
         set_rst(1'b1);
         run(6'h00, 6'h20, 1'b0, 1'b0);   // ADD
         run(6'h08, 6'h00, 1'b1, 1'b0);   // ADDI overflow
         run(6'h3F, 6'h00, 1'b0, 1'b0);   // invalid opcode
         run(6'h23, 6'h00, 1'b0, 1'b0);   // LW
         run(6'h2B, 6'h00, 1'b0, 1'b0);   // SW
         run(6'h04, 6'h00, 1'b0, 1'b1);   // BEQ taken
         run(6'h04, 6'h00, 1'b0, 1'b0);   // BEQ not taken
         run(6'h05, 6'h00, 1'b0, 1'b1);   // BNE not taken
         run(6'h05, 6'h00, 1'b0, 1'b0);   // BNE taken
         run(6'h00, 6'h0D, 1'b0, 1'b0);   // BREAK
         run(6'h00, 6'h22, 1'b1, 1'b0);   // SUB overflow
         run(6'h00, 6'h24, 1'b1, 1'b0);   // AND ignores overflow
         run(6'h00, 6'h3F, 1'b0, 1'b0);   // invalid funct
         run(6'h09, 6'h00, 1'b1, 1'b0);   // ADDIU never traps
         run(6'h00, 6'h20, 1'b1, 1'b0);   // ADD overflow
         for (int k = 0; k < 30; k++) begin
            case ($urandom_range(0, 9))
               0: begin ro = 6'h00; rf = 6'h20; end
               1: begin ro = 6'h00; rf = 6'h22; end
               2: begin ro = 6'h00; rf = 6'h24; end
               3: begin ro = 6'h00; rf = 6'h0D; end
               4: begin ro = 6'h08; rf = 6'($urandom); end
               5: begin ro = 6'h09; rf = 6'($urandom); end
               6: begin ro = 6'h23; rf = 6'($urandom); end
               7: begin ro = 6'h2B; rf = 6'($urandom); end
               8: begin ro = ($urandom_range(0, 1) == 0) ? 6'h04 : 6'h05; rf = 6'($urandom); end
               default: begin ro = 6'($urandom); rf = 6'($urandom); end
            endcase
            run(ro, rf, 1'($urandom), 1'($urandom));
         end
         if (s == 0) begin
            lw_reset();
            run(6'h00, 6'h20, 1'b0, 1'b0);
         end
         set_rst(1'b0);
      end
      stim_done = 1'b1;
   end

   // Monitor: compare every cycle of the selected instance against the scoreboard
   always @(negedge clk) begin
      logic r;
      cyc++;
      act = (sel == 0) ? act0 : (sel == 1) ? act1 : act2;
      r   = (sel == 0) ? rst0 : (sel == 1) ? rst1 : rst2;
      if (!r) begin
         n_checks++;
         if (act !== obs_t'('0)) begin
            n_fail++;
            $display("FAIL reset_state sel=%0d cyc=%0d actual=%h required=%h", sel, cyc, act, obs_t'('0));
         end
      end else begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL no_expect sel=%0d cyc=%0d actual=%h required=none", sel, cyc, act);
         end else begin
            expv = exp_q.pop_front();
            if (act !== expv) begin
               n_fail++;
               $display("FAIL cycle sel=%0d cyc=%0d actual=%h required=%h", sel, cyc, act, expv);
            end
         end
      end
      if (stim_done || cyc >= LIMIT) begin
         if (!stim_done) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout cyc=%0d actual=running required=done", cyc);
         end
         n_checks++;
         if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL leftover actual=%0d required=0", exp_q.size());
         end
         $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
         $finish;
      end
   end

endmodule
